// File: rtl/cv32e40p_apu_arbiter_if.sv
// APU req/gnt/rvalid bundle for NUM_PORTS lanes; the master drives requests, the slave answers.
// Result and response flags are shared by all lanes.
interface cv32e40p_apu_arbiter_if #(
    parameter int NUM_PORTS = 1,
    parameter int NARGS     = 3,
    parameter int WOP       = 6,
    parameter int NDSFLAGS  = 15,
    parameter int NUSFLAGS  = 5
);
    logic [NUM_PORTS-1:0]          req;
    logic [NUM_PORTS-1:0]          gnt;
    logic [NUM_PORTS*NARGS*32-1:0] operands;
    logic [NUM_PORTS*WOP-1:0]      op;
    logic [NUM_PORTS*NDSFLAGS-1:0] flags;
    logic [NUM_PORTS-1:0]          rvalid;
    logic [31:0]                   result;
    logic [NUSFLAGS-1:0]           rflags;

    modport master (output req, operands, op, flags, input gnt, rvalid, result, rflags);
    modport slave  (input req, operands, op, flags, output gnt, rvalid, result, rflags);
endinterface

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin sharing of one APU between NUM_CORES cores; responses are routed back
// in issue order through a FIFO of granted core IDs.
//
//  state  | meaning
//  IDLE   | free round-robin selection among requesting cores
//  LOCKED | request presented but not granted; selection and payload held on sel_q
module cv32e40p_apu_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int DEPTH     = 4,
    parameter int NARGS     = 3,
    parameter int WOP       = 6,
    parameter int NDSFLAGS  = 15,
    parameter int NUSFLAGS  = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    cv32e40p_apu_arbiter_if.slave        core_apu,
    cv32e40p_apu_arbiter_if.master       apu,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
    output logic                         protocol_err_o
);
    localparam int IW  = $clog2(NUM_CORES);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int OPW = NARGS * 32;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q;
    logic [IW-1:0] rr_q, sel_q, arb_sel, sel;
    logic [IW-1:0] id_fifo [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, empty, apu_req, handshake, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Scan offsets from the far end so the requester closest to rr_q wins.
    always_comb begin
        arb_sel = rr_q;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_apu.req[(int'(rr_q) + i) % NUM_CORES])
                arb_sel = IW'((int'(rr_q) + i) % NUM_CORES);
        end
    end

    assign sel       = (state_q == LOCKED) ? sel_q : arb_sel;
    assign apu_req   = rst_ni && (|core_apu.req) && !full;
    assign handshake = apu_req && apu.gnt[0];
    assign pop       = apu.rvalid[0] && !empty;

    assign apu.req      = apu_req;
    assign apu.operands = apu_req ? core_apu.operands[int'(sel)*OPW +: OPW] : '0;
    assign apu.op       = apu_req ? core_apu.op[int'(sel)*WOP +: WOP] : '0;
    assign apu.flags    = apu_req ? core_apu.flags[int'(sel)*NDSFLAGS +: NDSFLAGS] : '0;

    assign core_apu.gnt    = handshake ? (NUM_CORES'(1) << sel) : '0;
    assign core_apu.rvalid = pop ? (NUM_CORES'(1) << id_fifo[rd_ptr_q]) : '0;
    assign core_apu.result = rst_ni ? apu.result : '0;
    assign core_apu.rflags = rst_ni ? apu.rflags : '0;

    assign outstanding_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            rr_q           <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            protocol_err_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) id_fifo[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (apu_req && !apu.gnt[0]) begin
                        state_q <= LOCKED;
                        sel_q   <= arb_sel;
                    end
                end
                LOCKED: begin
                    if (!core_apu.req[sel_q]) begin
                        protocol_err_o <= 1'b1;
                        state_q        <= IDLE;
                    end else if (apu.gnt[0]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (handshake) begin
                id_fifo[wr_ptr_q] <= sel;
                wr_ptr_q          <= next_ptr(wr_ptr_q);
                rr_q              <= (sel == IW'(NUM_CORES - 1)) ? '0 : sel + 1'b1;
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CW'(handshake) - CW'(pop);

            // A response with nothing outstanding has no owner.
            if (apu.rvalid[0] && empty) protocol_err_o <= 1'b1;
        end
    end
endmodule
